// File: rtl/da_seq_ctrl.sv
// Bit-serial distributed-arithmetic sequencer: walks the three samples LSB-first,
// looks each bit slice up in an external table and accumulates y = sum 2^k*T(b_k).
module da_seq_ctrl #(
    parameter int W  = 8,
    parameter int YW = W + 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic signed [W-1:0]  x0,
    input  logic signed [W-1:0]  x1,
    input  logic signed [W-1:0]  x2,
    output logic [2:0]           table_in,
    input  logic signed [3:0]    table_out,
    output logic                 busy,
    output logic                 done,
    output logic signed [YW-1:0] y
);

    typedef enum logic {
        S_IDLE,
        S_RUN
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [W-1:0]        r_cnt;
    logic [W-1:0]        r_sx0;
    logic [W-1:0]        r_sx1;
    logic [W-1:0]        r_sx2;
    logic [YW-1:0]       r_acc;
    logic [YW-1:0]       r_y;
    logic                r_done;
    logic                w_last;
    logic [YW-1:0]       w_ext;
    logic [YW-1:0]       w_term;
    logic [YW-1:0]       w_sum;

    assign w_last = (r_cnt == W'(W - 1));
    assign w_ext  = {{(YW - 4){table_out[3]}}, table_out};
    assign w_term = w_ext << r_cnt;
    // The sign-bit slice carries weight -2^(W-1), so it is subtracted.
    assign w_sum  = w_last ? (r_acc - w_term) : (r_acc + w_term);

    assign table_in = (r_state == S_RUN) ? {r_sx2[0], r_sx1[0], r_sx0[0]} : 3'b000;
    assign busy     = (r_state == S_RUN);
    assign done     = r_done;
    assign y        = r_y;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_RUN;
            S_RUN:   if (w_last) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_sx0  <= '0;
            r_sx1  <= '0;
            r_sx2  <= '0;
            r_acc  <= '0;
            r_y    <= '0;
            r_done <= 1'b0;
        end else if (r_state == S_IDLE) begin
            r_done <= 1'b0;
            if (start) begin
                r_sx0 <= x0;
                r_sx1 <= x1;
                r_sx2 <= x2;
                r_acc <= '0;
                r_cnt <= '0;
            end
        end else begin
            r_acc <= w_sum;
            r_sx0 <= r_sx0 >> 1;
            r_sx1 <= r_sx1 >> 1;
            r_sx2 <= r_sx2 >> 1;
            r_cnt <= r_cnt + W'(1);
            if (w_last) begin
                r_y    <= w_sum;
                r_done <= 1'b1;
            end
        end
    end

endmodule

// File: doc/da_seq_ctrl.md
DA_SEQ_CTRL -- requirements
Module: da_seq_ctrl

Interface
REQ-001 Parameter: W, default 8, sample width in bits (two's complement); W >= 2.
REQ-002 Parameter: YW, default W+3, result width; YW = W+3 is the only supported value.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; reset = 0 clears all state immediately.
REQ-005 start  input  1  request to compute one result; sampled only in IDLE.
REQ-006 x0, x1, x2  input  W each  signed samples; sampled together with an accepted start.
REQ-007 table_in  output  3  address to the external 3-coefficient DA table: {x2 bit, x1 bit, x0 bit}.
REQ-008 table_out  input  4  signed table word for the current table_in; combinational, same cycle.
REQ-009 busy  output  1  high while a computation is in progress.
REQ-010 done  output  1  one-cycle pulse; y is valid from this cycle on.
REQ-011 y  output  YW  signed result; y = sum over k=0..W-2 of 2^k*T(b_k), minus 2^(W-1)*T(b_(W-1)).

Function
REQ-012 b_k = {x2[k], x1[k], x0[k]}; T(.) = the table_out value for that address.
REQ-013 Table contents: coefficients -2 (x0), 3 (x1), 1 (x2), so y = -2*x0 + 3*x1 + x2.
REQ-014 States are IDLE and RUN; a W-bit counter cnt runs 0..W-1 in RUN.
REQ-015 IDLE, start = 1 -> load x0..x2 into three shift registers, clear the accumulator, set cnt = 0, go to RUN, set busy = 1.
REQ-016 IDLE, start = 0 -> remain in IDLE; no state changes apart from clearing done.
REQ-017 In RUN: table_in = LSBs of the shift registers (bit cnt of each sample); in IDLE: table_in = 3'b000.
REQ-018 Each RUN cycle: sign-extend table_out to YW bits and shift it left by cnt.
REQ-019 Each RUN cycle: add the shifted word to the accumulator if cnt < W-1; subtract it if cnt = W-1 (sign bit).
REQ-020 Each RUN cycle, after the accumulate: shift the three shift registers right by 1 and increment cnt.
REQ-021 On the RUN edge with cnt = W-1: y <= final accumulator value, done <= 1, busy <= 0, go to IDLE.
REQ-022 Latency: start is accepted at edge E0; done and the new y appear at edge E(W), which is E8 for the default W.
REQ-023 done stays high for exactly one cycle.
REQ-024 y holds its value until the next done; busy and done are never high together.
REQ-025 start while busy is ignored and not queued; x0..x2 changes during RUN have no effect.
REQ-026 Back-to-back: start high in the cycle after done is accepted, giving one result every W+1 cycles at best.
REQ-027 Arithmetic is modulo 2^YW; with YW = W+3 no overflow occurs (default range -766..764).

Reset
REQ-028 reset = 0 forces IDLE and cnt = 0, and sets busy = 0, done = 0, y = 0, table_in = 0, accumulator = 0 and shift registers = 0, asynchronously.
REQ-029 Reset mid-RUN aborts the computation; no done is issued and y reads 0.
REQ-030 After release, the first rising edge with start = 1 starts a new computation normally.

Verification
REQ-031 x0=1, x1=0, x2=0, start -> done at E8, y=-2; table_in sequence in RUN = 1,0,0,0,0,0,0,0.
REQ-032 x0=-128, x1=127, x2=127 -> y=764; second run with x0=127, x1=-128, x2=-128 -> y=-766.
REQ-033 x0=5, x1=-3, x2=10 -> y=-9; start pulsed again at E3 and E5 -> ignored, exactly one done at E8.
REQ-034 start held high continuously -> done at E8, E17, E26; busy low only in the done cycles.
REQ-035 reset driven low at E4 of a run -> busy, done and y read 0 immediately and no done follows; after release, x0=0, x1=1, x2=0 -> y=3 W cycles after start.
REQ-036 The bench uses a behavioural model of the table and compares y to -2*x0+3*x1+x2 on every done, over 1000 random sample triples.
